// File: rtl/debounce.sv
// debounce: per-channel 2-flop synchroniser plus stable-time filter on a bank of buttons.
// Define DEBOUNCE_PULSE_EN to turn out into a 1-cycle pulse on each debounced press.
module debounce #(
    parameter int N = 5,
    parameter int STABLE_CYCLES = 2000000,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] button,
    output logic [N-1:0] out
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic [N-1:0] sync1, sync2, level, level_nxt;
    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] cnt_nxt [N];
    // Any cycle where sync2 matches the level throws away the partial count.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            level_nxt[i] = (sync2[i] != level[i] && cnt[i] == LAST) ? sync2[i] : level[i];
            cnt_nxt[i] = (sync2[i] == level[i] || cnt[i] == LAST) ? '0 : cnt[i] + CNT_W'(1);
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            cnt <= '{default: '0};
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            level <= level_nxt;
            cnt <= cnt_nxt;
        end
    end
`ifdef DEBOUNCE_PULSE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) out <= '0;
        else out <= level_nxt & ~level;
    end
`else
    assign out = level;
`endif
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed checks of debounce at STABLE_CYCLES=16, 1 and the default.
module tb_debounce;
    logic clock = 1'b0;
    logic reset;
    logic [4:0] btn_a, btn_b, btn_c;
    logic [4:0] out_a, out_b, out_c;
    int passed = 0;
    int total = 0;
    int errors = 0;

    always #5 clock = ~clock;

    debounce #(.N(5), .STABLE_CYCLES(16)) dut_a (.clock(clock), .reset(reset), .button(btn_a), .out(out_a));
    debounce #(.N(5)) dut_b (.clock(clock), .reset(reset), .button(btn_b), .out(out_b));
    debounce #(.N(5), .STABLE_CYCLES(1)) dut_c (.clock(clock), .reset(reset), .button(btn_c), .out(out_c));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn_a = 5'b11111;
        btn_b = 5'b00000;
        btn_c = 5'b11111;
        #1;
        chk("reset_a_t1", out_a, 5'b00000);
        chk("reset_b_t1", out_b, 5'b00000);
        chk("reset_c_t1", out_c, 5'b00000);
        #50;
        chk("reset_a_t51", out_a, 5'b00000);
        #49;
        chk("reset_a_t100", out_a, 5'b00000);
        chk("reset_c_t100", out_c, 5'b00000);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("post_reset_a", out_a, (i == 18) ? 5'b11111 : 5'b00000);
            chk("post_reset_c", out_c, (i >= 3) ? 5'b11111 : 5'b00000);
        end
        btn_a = 5'b00000;
        btn_c = 5'b00000;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("release_all_a", out_a, (i < 18) ? 5'b11111 : 5'b00000);
            chk("release_all_c", out_c, (i < 3) ? 5'b11111 : 5'b00000);
        end
        btn_a = 5'b00001;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("press0", out_a, (i == 18) ? 5'b00001 : 5'b00000);
        end
        btn_a = 5'b00000;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("release0", out_a, (i < 18) ? 5'b00001 : 5'b00000);
        end
        // bounce on channel 1: high 10, low 3, high 10, low 2, then steady high
        btn_a = 5'b00010;
        for (int i = 1; i <= 25; i++) begin
            tick();
            chk("bounce", out_a, 5'b00000);
            if (i == 10 || i == 23) btn_a = 5'b00000;
            if (i == 13 || i == 25) btn_a = 5'b00010;
        end
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("bounce_settle", out_a, (i == 18) ? 5'b00010 : 5'b00000);
        end
        btn_a = 5'b00000;
        for (int i = 1; i <= 18; i++) tick();
        chk("bounce_release", out_a, 5'b00000);
        // channels 3 and 4 together; channel 4 dips low for one cycle after edge 8
        btn_a = 5'b11000;
        for (int i = 1; i <= 27; i++) begin
            tick();
            chk("simul", out_a, {(i >= 27) ? 1'b1 : 1'b0, (i >= 18) ? 1'b1 : 1'b0, 3'b000});
            if (i == 8) btn_a = 5'b01000;
            if (i == 9) btn_a = 5'b11000;
        end
        btn_a = 5'b00000;
        for (int i = 1; i <= 18; i++) tick();
        chk("simul_release", out_a, 5'b00000);
        // short tap on the default-parameter instance
        btn_b = 5'b00100;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (i % 500 == 0) chk("tap_hold", out_b, 5'b00000);
        end
        btn_b = 5'b00000;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            if (i % 500 == 0) chk("tap_after", out_b, 5'b00000);
        end
        // reset mid-count while channel 2 is already debounced high
        btn_a = 5'b00100;
        btn_c = 5'b00100;
        for (int i = 1; i <= 18; i++) tick();
        chk("pre_midreset_a", out_a, 5'b00100);
        chk("pre_midreset_c", out_c, 5'b00100);
        btn_a = 5'b00101;
        for (int i = 1; i <= 10; i++) tick();
        chk("midcount_a", out_a, 5'b00100);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_a", out_a, 5'b00000);
        chk("async_reset_c", out_c, 5'b00000);
        tick();
        tick();
        chk("held_reset_a", out_a, 5'b00000);
        reset = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            chk("after_midreset_a", out_a, (i == 18) ? 5'b00101 : 5'b00000);
            chk("after_midreset_c", out_c, (i >= 3) ? 5'b00100 : 5'b00000);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
